// File: rtl/stoch_pkg.sv
// Shared types and helpers for the stochastic-to-binary output stage.
package stoch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int STOCH_CNT_W = 8;

    // Clamp a window total (up to 2^w) into a w-bit magnitude.
    function automatic logic [31:0] stoch_sat(input logic [31:0] total, input int unsigned w);
        logic [31:0] lim;
        lim = (32'd1 << w) - 32'd1;
        return (total > lim) ? lim : total;
    endfunction

endpackage

// File: rtl/stoch_accum.sv
// Window accumulator: accepted-bit counter and ones counter, with a flag for
// the final bit of the window.
module stoch_accum
    import stoch_pkg::*;
#(
    parameter int CNT_W = STOCH_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             acc,
    input  logic             z,
    output logic [CNT_W:0]   ones,
    output logic             last
);

    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W:0]   r_ones;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bit_cnt <= '0;
            r_ones    <= '0;
        end else if (clr) begin
            r_bit_cnt <= '0;
            r_ones    <= '0;
        end else if (acc) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_ones    <= r_ones + {{CNT_W{1'b0}}, z};
        end
    end

    assign ones = r_ones;
    assign last = acc & (&r_bit_cnt);

endmodule

// File: rtl/stoch_to_bin.sv
// Counts ones over a 2^CNT_W-bit window and presents the saturated count on a
// valid/ready output register. STOCH_THRESH_EN adds thr input and edge_flag
// output ('edge' is a reserved word, hence the name).
module stoch_to_bin
    import stoch_pkg::*;
#(
    parameter int CNT_W = STOCH_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             z,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [CNT_W-1:0] pix,
    output logic             out_valid,
`ifdef STOCH_THRESH_EN
    input  logic [CNT_W-1:0] thr,
    output logic             edge_flag,
`endif
    input  logic             out_ready
);

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_pix;
    logic             w_acc;
    logic             w_clr;
    logic             w_last;
    logic [CNT_W:0]   w_ones;
    logic [CNT_W:0]   w_total;
    logic [CNT_W-1:0] w_sat;

    assign w_acc   = in_valid & r_in_ready;
    assign w_clr   = start & ((r_state == ST_IDLE) | ((r_state == ST_HOLD) & out_ready));
    assign w_total = w_ones + {{CNT_W{1'b0}}, z};
    assign w_sat   = CNT_W'(stoch_sat(32'(w_total), CNT_W));

    stoch_accum #(.CNT_W(CNT_W)) u_accum (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .acc  (w_acc),
        .z    (z),
        .ones (w_ones),
        .last (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_pix       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_RUN;
                        r_in_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_last) begin
                        r_pix       <= w_sat;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b0;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        // A start here chains straight into the next window.
                        if (start) begin
                            r_state    <= ST_RUN;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef STOCH_THRESH_EN
    logic r_edge;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_edge <= 1'b0;
        end else if ((r_state == ST_RUN) && w_last) begin
            r_edge <= (w_sat >= thr);
        end
    end

    assign edge_flag = r_edge;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign pix       = r_pix;

endmodule

// File: tb/tb_stoch_to_bin.sv
// Randomized checks of stoch_to_bin at CNT_W=8 and CNT_W=4 against a
// window-count reference model.
module tb_stoch_to_bin;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       s8_start = 0, s8_z = 0, s8_iv = 0, s8_ordy = 0;
    logic       s8_ir, s8_ov;
    logic [7:0] s8_pix;
    logic       s4_start = 0, s4_z = 0, s4_iv = 0, s4_ordy = 0;
    logic       s4_ir, s4_ov;
    logic [3:0] s4_pix;
`ifdef STOCH_THRESH_EN
    logic [7:0] s8_thr = 8'd0;
    logic [3:0] s4_thr = 4'd0;
    logic       s8_edge, s4_edge;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stoch_to_bin #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8_start), .z(s8_z), .in_valid(s8_iv),
        .in_ready(s8_ir), .pix(s8_pix), .out_valid(s8_ov),
`ifdef STOCH_THRESH_EN
        .thr(s8_thr), .edge_flag(s8_edge),
`endif
        .out_ready(s8_ordy)
    );

    stoch_to_bin #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4_start), .z(s4_z), .in_valid(s4_iv),
        .in_ready(s4_ir), .pix(s4_pix), .out_valid(s4_ov),
`ifdef STOCH_THRESH_EN
        .thr(s4_thr), .edge_flag(s4_edge),
`endif
        .out_ready(s4_ordy)
    );

    function automatic bit get_ir(input int w);
        return (w == 8) ? s8_ir : s4_ir;
    endfunction

    function automatic bit get_ov(input int w);
        return (w == 8) ? s8_ov : s4_ov;
    endfunction

    function automatic int get_pix(input int w);
        return (w == 8) ? int'(s8_pix) : int'(s4_pix);
    endfunction

    task automatic drive(input int w, input bit st, input bit zb, input bit iv, input bit ordy);
        if (w == 8) begin
            s8_start = st; s8_z = zb; s8_iv = iv; s8_ordy = ordy;
        end else begin
            s4_start = st; s4_z = zb; s4_iv = iv; s4_ordy = ordy;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_window(input int w);
        drive(w, 1, 0, 0, 0);
        tick();
        drive(w, 0, 0, 0, 0);
        total++;
        if (get_ir(w) !== 1'b1 || get_ov(w) !== 1'b0) begin
            bad++;
            $display("FAIL start_w%0d: in_ready=%0b out_valid=%0b want 1/0", w, get_ir(w), get_ov(w));
        end
    endtask

    // Feeds one window (already in RUN) with n_ones ones in random order,
    // optionally with random in_valid gaps; checks the result and returns it.
    task automatic run_window(input int w, input int n_ones, input bit gaps, output int exp_pix);
        int len = 1 << w;
        bit bits[$];
        int acc = 0, ones = 0, cyc = 0;
        bit early = 0, take, zb, iv, tmp;
        for (int i = 0; i < len; i++) bits.push_back(i < n_ones);
        for (int i = 0; i < len; i++) begin
            int j = $urandom_range(len - 1);
            tmp = bits[i]; bits[i] = bits[j]; bits[j] = tmp;
        end
        while (acc < len && cyc < 20 * len) begin
            if (get_ov(w)) early = 1;
            iv = gaps ? ($urandom_range(3) != 0) : 1'b1;
            zb = bits[acc];
            drive(w, 0, zb, iv, 0);
            take = iv && get_ir(w);
            tick();
            if (take) begin
                acc++;
                ones += int'(zb);
            end
            cyc++;
        end
        drive(w, 0, 0, 0, 0);
        exp_pix = (ones > len - 1) ? len - 1 : ones;
        total++;
        if (early || get_ov(w) !== 1'b1) begin
            bad++;
            $display("FAIL ov_timing_w%0d: early=%0b out_valid=%0b want 0/1", w, early, get_ov(w));
        end
        total++;
        if (get_pix(w) !== exp_pix) begin
            bad++;
            $display("FAIL pix_w%0d_ones%0d: got %0d want %0d", w, n_ones, get_pix(w), exp_pix);
        end
        total++;
        if (get_ir(w) !== 1'b0) begin
            bad++;
            $display("FAIL ir_hold_w%0d: got %0b want 0", w, get_ir(w));
        end
    endtask

    task automatic accept(input int w, input bit st_next);
        drive(w, st_next, 0, 0, 1);
        tick();
        drive(w, 0, 0, 0, 0);
        total++;
        if (get_ov(w) !== 1'b0 || get_ir(w) !== st_next) begin
            bad++;
            $display("FAIL accept_w%0d: out_valid=%0b in_ready=%0b want 0/%0b", w, get_ov(w), get_ir(w), st_next);
        end
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (3) tick();
        total++;
        if (s8_pix !== 8'd0 || s8_ov !== 1'b0 || s8_ir !== 1'b0 ||
            s4_pix !== 4'd0 || s4_ov !== 1'b0 || s4_ir !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: pix8=%0d ov8=%0b ir8=%0b pix4=%0d ov4=%0b ir4=%0b want all 0",
                     s8_pix, s8_ov, s8_ir, s4_pix, s4_ov, s4_ir);
        end
        rst = 1;
        begin_window(8);
        for (int i = 0; i < 50; i++) begin
            drive(8, 0, 1, 1, 0);
            tick();
        end
        rst = 0;
        repeat (2) tick();
        rst = 1;
        drive(8, 0, 0, 0, 0);
        total++;
        if (s8_pix !== 8'd0 || s8_ov !== 1'b0 || s8_ir !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_run: pix=%0d ov=%0b ir=%0b want 0/0/0", s8_pix, s8_ov, s8_ir);
        end
        repeat (5) tick();
        total++;
        if (s8_ov !== 1'b0 || s8_ir !== 1'b0) begin
            bad++;
            $display("FAIL reset_stays_idle: ov=%0b ir=%0b want 0/0", s8_ov, s8_ir);
        end
    endtask

    task automatic test_saturation();
        int e;
        begin_window(8);
        run_window(8, 256, 0, e);
        accept(8, 0);
        begin_window(4);
        run_window(4, 16, 1, e);
        accept(4, 0);
    endtask

    task automatic test_gapped();
        int c = 0, acc = 0, ones = 0;
        bit zb = 1, iv, take, ir_bad = 0;
        begin_window(4);
        while (!s4_ov && c < 100) begin
            if (s4_ir !== 1'b1) ir_bad = 1;
            iv = (c % 3) != 2;
            drive(4, 0, zb, iv, 0);
            take = iv && s4_ir;
            tick();
            if (take) begin
                acc++;
                ones += int'(zb);
                zb = ~zb;
            end
            c++;
        end
        drive(4, 0, 0, 0, 0);
        total++;
        if (ir_bad || acc !== 16) begin
            bad++;
            $display("FAIL gapped_count: accepted=%0d ir_drop=%0b want 16/0", acc, ir_bad);
        end
        total++;
        if (s4_pix !== 4'(ones)) begin
            bad++;
            $display("FAIL gapped_pix: got %0d want %0d", s4_pix, ones);
        end
        accept(4, 0);
    endtask

    task automatic test_back_to_back();
        int e, e2;
        begin_window(4);
        run_window(4, $urandom_range(1, 14), 1, e);
        for (int i = 0; i < 10; i++) begin
            drive(4, 1'($urandom_range(1)), 1'(i & 1), 1, 0);
            tick();
            total++;
            if (s4_pix !== 4'(e) || s4_ov !== 1'b1 || s4_ir !== 1'b0) begin
                bad++;
                $display("FAIL hold_cyc%0d: pix=%0d ov=%0b ir=%0b want %0d/1/0", i, s4_pix, s4_ov, s4_ir, e);
            end
        end
        accept(4, 1);
        run_window(4, $urandom_range(0, 16), 1, e2);
        accept(4, 0);
        total++;
        if (s4_pix !== 4'(e2)) begin
            bad++;
            $display("FAIL pix_retained: got %0d want %0d", s4_pix, e2);
        end
    endtask

    task automatic test_midreset();
        int e;
        begin_window(8);
        run_window(8, 256, 1, e);
        rst = 0;
        tick();
        rst = 1;
        total++;
        if (s8_pix !== 8'd0 || s8_ov !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_hold: pix=%0d ov=%0b want 0/0", s8_pix, s8_ov);
        end
        begin_window(8);
        for (int i = 0; i < 100; i++) begin
            drive(8, 0, 1, 1, 0);
            tick();
        end
        rst = 0;
        tick();
        rst = 1;
        drive(8, 0, 0, 0, 0);
        total++;
        if (s8_ir !== 1'b0 || s8_ov !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_window: ir=%0b ov=%0b want 0/0", s8_ir, s8_ov);
        end
        begin_window(8);
        run_window(8, 0, 0, e);
        accept(8, 0);
    endtask

    task automatic test_random();
        int e;
        for (int k = 0; k < 4; k++) begin
            begin_window(8);
            run_window(8, $urandom_range(0, 256), 1, e);
            accept(8, 0);
            begin_window(4);
            run_window(4, $urandom_range(0, 16), 1, e);
            accept(4, 0);
        end
    endtask

`ifdef STOCH_THRESH_EN
    task automatic test_thresh();
        int e;
        s8_thr = 8'd128;
        begin_window(8);
        run_window(8, 128, 1, e);
        total++;
        if (s8_edge !== 1'b1) begin
            bad++;
            $display("FAIL thresh_128: edge=%0b want 1", s8_edge);
        end
        accept(8, 1);
        run_window(8, 127, 1, e);
        total++;
        if (s8_edge !== 1'b0) begin
            bad++;
            $display("FAIL thresh_127: edge=%0b want 0", s8_edge);
        end
        accept(8, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_saturation();
        test_gapped();
        test_back_to_back();
        test_midreset();
        test_random();
`ifdef STOCH_THRESH_EN
        test_thresh();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stoch_to_bin.md
Name: stoch_to_bin

Overview:
Downstream stage of the stochastic edge-detect core. Consumes the serial stochastic output bitstream `z` and counts its ones over a fixed window of 2^CNT_W accepted bits. Converts that count back to a binary pixel magnitude. Delivers the result through a valid/ready output register, so one window yields one edge-magnitude pixel.

Parameters:
CNT_W, 8, log2 of window length; also the output pixel width (window = 2^CNT_W accepted bits)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (rst=0 resets on the next rising clk)
start  in  1  begin a new window; honoured only as described under Behaviour
z  in  1  stochastic bit from the edge-detect core
in_valid  in  1  qualifies z; a bit is accepted when in_valid & in_ready
in_ready  out  1  high only while a window is accumulating
pix  out  CNT_W  decoded magnitude, saturated
out_valid  out  1  pix is valid; held until accepted
out_ready  in  1  consumer accepts pix when out_valid & out_ready

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; bit_cnt=0; ones=0; pix=0; out_valid=0; in_ready=0. Reset overrides everything, including mid-window and mid-HOLD; any partial window is discarded.
- FSM states: IDLE, RUN, HOLD.
- IDLE: in_ready=0, out_valid=0.
  - start=1 -> RUN; clear bit_cnt and ones on the same edge.
- RUN: in_ready=1.
  - Each accepted bit: bit_cnt+1 (CNT_W bits, wraps); ones += z (CNT_W+1 bits, no overflow possible).
  - Cycles with in_valid=0 do not count.
  - start is ignored in RUN.
- Last accepted bit (bit_cnt==2^CNT_W-1 and accepted):
  - total = ones + z.
  - pix <= (total==2^CNT_W) ? all-ones : total[CNT_W-1:0].
  - out_valid <= 1; state -> HOLD.
  - Latency: out_valid rises on the edge that accepts the final bit, i.e. visible in the next cycle.
- HOLD: in_ready=0; pix and out_valid stable; z/in_valid ignored.
  - out_ready=1 and start=1 -> RUN with counters cleared (back-to-back windows, no idle cycle); out_valid <= 0.
  - out_ready=1 and start=0 -> IDLE; out_valid <= 0.
  - pix retains its last value after acceptance until overwritten.
- Result semantics: an all-zero window gives pix=0. An all-one window gives pix=2^CNT_W-1 (saturated). Otherwise pix = exact count of ones.
- in_ready is a registered function of state only; it never depends combinationally on out_ready.

Optional Feature:
STOCH_THRESH_EN:
- Defined: adds input thr[CNT_W-1:0] and output edge (1 bit).
  - edge is registered on the same edge as pix: edge = (saturated total >= thr).
  - edge is valid with out_valid; reset value 0; held in HOLD.
- Undefined: thr and edge ports do not exist; pix/out_valid behaviour is identical.

Decomposition:
- Package stoch_pkg:
  - state enum typedef (IDLE/RUN/HOLD);
  - default window width constant STOCH_CNT_W=8;
  - saturation helper function (CNT_W+1 -> CNT_W).
- One natural sub-module, stoch_accum:
  - bit_cnt and ones registers with clear/accept inputs;
  - last-bit flag output.
- stoch_to_bin keeps the FSM, the output register and the optional threshold compare.

Test Plan:
- Reset: hold rst=0 for 2 clks mid-RUN at CNT_W=8 -> pix=0, out_valid=0, in_ready=0. After release with start=0 -> stays IDLE.
- Saturation, CNT_W=8: start, then 256 consecutive in_valid with z=1 -> pix=255; out_valid=1 exactly one cycle after the 256th accepted bit.
- Gapped input, CNT_W=4: z alternates 1,0, with in_valid=0 on every 3rd cycle -> exactly 16 accepted bits; pix=8; in_ready=1 throughout RUN.
- Backpressure, CNT_W=4:
  - Complete a window, hold out_ready=0 for 10 cycles -> pix/out_valid stable, in_ready=0, toggling z has no effect.
  - Then out_ready=1 with start=1 -> in_ready=1 the next cycle and a new window counts from 0.
- Mid-window reset, CNT_W=8: after 100 bits of z=1, pulse rst=0 for one clk. Then start with 256 bits of z=0 -> pix=0.
- STOCH_THRESH_EN, CNT_W=8, thr=128: window with 128 ones -> edge=1, pix=128. Window with 127 ones -> edge=0, pix=127.
